// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter and register stage for the common data bus.
// Grants one functional-unit request per cycle (combinational one-hot grant)
// and broadcasts the winner's result, ROB tag and index one cycle later.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   fu_req       per-FU result-valid requests (level-held until granted)
//   fu_result    packed results, FU i in slice i
//   fu_tag       packed ROB tags, FU i in slice i
//   flush        pipeline flush (present only when CDB_FLUSH_EN is defined)
//   fu_grant     one-hot grant, combinational
//   cdb_valid    broadcast valid, registered
//   cdb_result   broadcast result, registered
//   cdb_tag      broadcast ROB tag, registered
//   cdb_src      index of the winning FU, registered
//
// Optional feature macro: CDB_FLUSH_EN (adds flush port; a flush cycle
// suppresses the grant and holds the round-robin pointer).
module cdb_arbiter #(
    parameter int unsigned WIDTH     = 31,
    parameter int unsigned TAG_WIDTH = 4,
    parameter int unsigned N_FU      = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_FU-1:0]                 fu_req,
    input  logic [N_FU*(WIDTH+1)-1:0]       fu_result,
    input  logic [N_FU*(TAG_WIDTH+1)-1:0]   fu_tag,
`ifdef CDB_FLUSH_EN
    input  logic                            flush,
`endif
    output logic [N_FU-1:0]                 fu_grant,
    output logic                            cdb_valid,
    output logic [WIDTH:0]                  cdb_result,
    output logic [TAG_WIDTH:0]              cdb_tag,
    output logic [$clog2(N_FU)-1:0]         cdb_src
);

    localparam int unsigned S  = $clog2(N_FU);
    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned TW = TAG_WIDTH + 1;

    logic [S-1:0]  ptr;
    logic [S-1:0]  scan_idx;
    logic [S-1:0]  win_idx;
    logic          win_found;
    logic          grant_en;
    logic          flush_act;
    logic [RW-1:0] result_arr [N_FU];
    logic [TW-1:0] tag_arr    [N_FU];

`ifdef CDB_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // Unpack the per-FU payload slices.
    always_comb begin
        for (int unsigned i = 0; i < N_FU; i++) begin
            result_arr[i] = fu_result[i*RW +: RW];
            tag_arr[i]    = fu_tag[i*TW +: TW];
        end
    end

    // Priority scan starting at ptr; index arithmetic wraps in S bits
    // because N_FU is a power of two.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < N_FU; k++) begin
            scan_idx = ptr + S'(k);
            if (!win_found && fu_req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Reset and flush both suppress the grant in the current cycle.
    assign grant_en = win_found && !reset && !flush_act;
    assign fu_grant = grant_en ? (N_FU'(1) << win_idx) : '0;

    // Pointer update and broadcast register; data/tag/src hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            cdb_valid  <= 1'b0;
            cdb_result <= '0;
            cdb_tag    <= '0;
            cdb_src    <= '0;
        end else if (grant_en) begin
            ptr        <= win_idx + S'(1);
            cdb_valid  <= 1'b1;
            cdb_result <= result_arr[win_idx];
            cdb_tag    <= tag_arr[win_idx];
            cdb_src    <= win_idx;
        end else begin
            cdb_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter (default parameters, N_FU=4).
// FU i is driven with result = base + i and tag = tag_base + i, so the
// broadcast value identifies which slice the result mux selected.
module tb_cdb_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   fu_req;
    logic [127:0] fu_result;
    logic [19:0]  fu_tag;
    logic [3:0]   fu_grant;
    logic         cdb_valid;
    logic [31:0]  cdb_result;
    logic [4:0]   cdb_tag;
    logic [1:0]   cdb_src;
`ifdef CDB_FLUSH_EN
    logic         flush;
`endif

    cdb_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .fu_req     (fu_req),
        .fu_result  (fu_result),
        .fu_tag     (fu_tag),
`ifdef CDB_FLUSH_EN
        .flush      (flush),
`endif
        .fu_grant   (fu_grant),
        .cdb_valid  (cdb_valid),
        .cdb_result (cdb_result),
        .cdb_tag    (cdb_tag),
        .cdb_src    (cdb_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] res;
        logic [4:0]  tag;
        logic [3:0]  exp_grant;
        logic        exp_valid;
        logic [31:0] exp_result;
        logic [4:0]  exp_tag;
        logic [1:0]  exp_src;
    } vec_t;

    vec_t vecs [19];
    int   n_checks;
    int   n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [31:0] res, input logic [4:0] tag);
        fu_req = req;
        for (int i = 0; i < 4; i++) begin
            fu_result[i*32 +: 32] = res + 32'(i);
            fu_tag[i*5 +: 5]      = tag + 5'(i);
        end
    endtask

    task automatic check_cdb(input string name, input logic v, input logic [31:0] r,
                             input logic [4:0] t, input logic [1:0] s);
        check({name, ".valid"},  64'(cdb_valid),  64'(v));
        check({name, ".result"}, 64'(cdb_result), 64'(r));
        check({name, ".tag"},    64'(cdb_tag),    64'(t));
        check({name, ".src"},    64'(cdb_src),    64'(s));
    endtask

    initial begin
        int exp_ptr;
        clk      = 1'b0;
        reset    = 1'b1;
        n_checks = 0;
        n_err    = 0;
`ifdef CDB_FLUSH_EN
        flush    = 1'b0;
`endif
        drive(4'b0000, 32'h0, 5'd0);

        //          rst  req      res           tag    grant    v  result        tag    src
        vecs[0]  = '{1'b1, 4'b1111, 32'h0,        5'd0,  4'b0000, 0, 32'h0,        5'd0,  2'd0};
        vecs[1]  = '{1'b1, 4'b1111, 32'h0,        5'd0,  4'b0000, 0, 32'h0,        5'd0,  2'd0};
        // rotation 0,1,2,3,0 with wrap
        vecs[2]  = '{1'b0, 4'b1111, 32'h10000000, 5'd0,  4'b0001, 1, 32'h10000000, 5'd0,  2'd0};
        vecs[3]  = '{1'b0, 4'b1111, 32'h20000000, 5'd1,  4'b0010, 1, 32'h20000001, 5'd2,  2'd1};
        vecs[4]  = '{1'b0, 4'b1111, 32'h30000000, 5'd2,  4'b0100, 1, 32'h30000002, 5'd4,  2'd2};
        vecs[5]  = '{1'b0, 4'b1111, 32'h40000000, 5'd3,  4'b1000, 1, 32'h40000003, 5'd6,  2'd3};
        vecs[6]  = '{1'b0, 4'b1111, 32'h50000000, 5'd4,  4'b0001, 1, 32'h50000000, 5'd4,  2'd0};
        // idle three cycles: valid drops, data/tag/src hold, ptr stays at 1
        vecs[7]  = '{1'b0, 4'b0000, 32'hFFFFFFF0, 5'd20, 4'b0000, 0, 32'h50000000, 5'd4,  2'd0};
        vecs[8]  = '{1'b0, 4'b0000, 32'hFFFFFFF0, 5'd20, 4'b0000, 0, 32'h50000000, 5'd4,  2'd0};
        vecs[9]  = '{1'b0, 4'b0000, 32'hFFFFFFF0, 5'd20, 4'b0000, 0, 32'h50000000, 5'd4,  2'd0};
        // ptr=1: FU2 wins over FU0; FU2 carries DEADBEEF / tag 5
        vecs[10] = '{1'b0, 4'b0101, 32'hDEADBEED, 5'd3,  4'b0100, 1, 32'hDEADBEEF, 5'd5,  2'd2};
        // fairness: ptr=3 grants FU3, then FU0 despite FU3 re-requesting
        vecs[11] = '{1'b0, 4'b1001, 32'h00000100, 5'd8,  4'b1000, 1, 32'h00000103, 5'd11, 2'd3};
        vecs[12] = '{1'b0, 4'b1001, 32'h00000200, 5'd9,  4'b0001, 1, 32'h00000200, 5'd9,  2'd0};
        vecs[13] = '{1'b0, 4'b1001, 32'h00000300, 5'd10, 4'b1000, 1, 32'h00000303, 5'd13, 2'd3};
        vecs[14] = '{1'b0, 4'b0110, 32'h00000007, 5'd0,  4'b0010, 1, 32'h00000008, 5'd1,  2'd1};
        // ptr=2: scan wraps past 3 and 0 to reach FU1
        vecs[15] = '{1'b0, 4'b0010, 32'h00000010, 5'd20, 4'b0010, 1, 32'h00000011, 5'd21, 2'd1};
        // mid-stream reset clears everything and returns ptr to 0
        vecs[16] = '{1'b1, 4'b1000, 32'h0,        5'd0,  4'b0000, 0, 32'h0,        5'd0,  2'd0};
        vecs[17] = '{1'b0, 4'b1010, 32'h00000020, 5'd0,  4'b0010, 1, 32'h00000021, 5'd1,  2'd1};
        vecs[18] = '{1'b0, 4'b1010, 32'h00000040, 5'd16, 4'b1000, 1, 32'h00000043, 5'd19, 2'd3};

        for (int v = 0; v < 19; v++) begin
            @(negedge clk);
            reset = vecs[v].rst;
            drive(vecs[v].req, vecs[v].res, vecs[v].tag);
            #1;
            check($sformatf("v%0d.grant", v), 64'(fu_grant), 64'(vecs[v].exp_grant));
            @(posedge clk);
            #1;
            check_cdb($sformatf("v%0d", v), vecs[v].exp_valid, vecs[v].exp_result,
                      vecs[v].exp_tag, vecs[v].exp_src);
        end

        // cdb_valid pulses for exactly one cycle per grant (ptr=0 here)
        @(negedge clk);
        drive(4'b0100, 32'hCAFE0000, 5'd7);
        #1;
        check("pulse.grant", 64'(fu_grant), 64'h4);
        @(posedge clk);
        #1;
        check_cdb("pulse.bcast", 1'b1, 32'hCAFE0002, 5'd9, 2'd2);
        @(negedge clk);
        drive(4'b0000, 32'h0, 5'd0);
        #1;
        check("pulse.idle_grant", 64'(fu_grant), 64'h0);
        @(posedge clk);
        #1;
        check_cdb("pulse.drop", 1'b0, 32'hCAFE0002, 5'd9, 2'd2);

        // all FUs requesting continuously: strict rotation from ptr=3
        exp_ptr = 3;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive(4'b1111, 32'(c) << 8, 5'(c));
            #1;
            check($sformatf("rr%0d.grant", c), 64'(fu_grant), 64'(1) << exp_ptr);
            @(posedge clk);
            #1;
            check_cdb($sformatf("rr%0d", c), 1'b1, (32'(c) << 8) + 32'(exp_ptr),
                      5'(c) + 5'(exp_ptr), 2'(exp_ptr));
            exp_ptr = (exp_ptr + 1) % 4;
        end

`ifdef CDB_FLUSH_EN
        // flush suppresses the grant and holds ptr (=3); FU1 wins afterwards
        @(negedge clk);
        flush = 1'b1;
        drive(4'b0010, 32'h0000AA00, 5'd2);
        #1;
        check("flush.grant", 64'(fu_grant), 64'h0);
        @(posedge clk);
        #1;
        check("flush.valid", 64'(cdb_valid), 64'h0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush.after_grant", 64'(fu_grant), 64'h2);
        @(posedge clk);
        #1;
        check_cdb("flush.after", 1'b1, 32'h0000AA01, 5'd3, 2'd1);
`endif

        @(negedge clk);
        drive(4'b0000, 32'h0, 5'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
